// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: FSM state codes and
// the instruction constants that fetch_unit and its neighbours agree on.
package fetch_pkg;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;

endpackage

// File: rtl/fetch_pc_next_sel.sv
// Next-PC selection for the fetch stage: sequential pc+4 or a redirect
// target, plus the word-alignment check on that target.
module pc_next_sel (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc    = redirect_valid ? redirect_target : (pc + 32'd4);
    misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and presents
// the current instruction. Optional perf counters under FETCH_PERF_CNT_EN.
//
// state   | meaning
// S_FETCH | imem_req high, waiting for imem_ready (bounded by FETCH_TIMEOUT)
// S_EXEC  | instruction held for decode; advance/redirect when pc_enable
// S_HALT  | misaligned redirect or bus timeout; only rst leaves
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic        bus_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] retired
`endif
);

  localparam int CNT_W = $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  logic [1:0]       state;
  logic [31:0]      ir;
  logic [CNT_W-1:0] fetch_cnt;
  logic [31:0]      next_pc;
  logic             misaligned;

  pc_next_sel u_pc_next_sel (
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .next_pc         (next_pc),
    .misaligned      (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      ir           <= NOP_INSTR;
      fetch_cnt    <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir    <= imem_rdata;
            state <= S_EXEC;
          end else if (fetch_cnt == TMO_LAST) begin
            bus_err <= 1'b1;
            state   <= S_HALT;
          end else begin
            fetch_cnt <= fetch_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          // Without pc_enable the instruction is held, redirect included.
          if (pc_enable) begin
            if (misaligned) begin
              misalign_err <= 1'b1;
              state        <= S_HALT;
            end else begin
              pc        <= next_pc;
              fetch_cnt <= '0;
              state     <= S_FETCH;
            end
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      retired      <= '0;
    end else if (state == S_EXEC) begin
      if (!pc_enable) begin
        stall_cycles <= stall_cycles + 32'd1;
      end else if (!misaligned) begin
        retired <= retired + 32'd1;
      end
    end
  end
`endif

  always_comb begin
    imem_req    = (state == S_FETCH);
    imem_addr   = pc;
    instr_valid = (state == S_EXEC);
    instr       = instr_valid ? ir : NOP_INSTR;
    opcode      = instr[6:0];
    pc_plus4    = pc + 32'd4;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, timeout/reset sequences and a
// randomized run against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LW   = 32'h0000_2083;
  localparam logic [31:0] ADDI = 32'h0040_0093;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, pc_enable, redirect_valid, imem_ready;
  logic [31:0] redirect_target, imem_rdata;
  logic        imem_req, instr_valid, misalign_err, bus_err;
  logic [31:0] imem_addr, pc, pc_plus4, instr;
  logic [6:0]  opcode;
  logic        imem_req_2, instr_valid_2, misalign_err_2, bus_err_2;
  logic [31:0] imem_addr_2, pc_2, pc_plus4_2, instr_2;
  logic [6:0]  opcode_2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, retired, stall_cycles_2, retired_2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pc_enable(pc_enable), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .misalign_err(misalign_err), .bus_err(bus_err)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .retired(retired)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FETCH_TIMEOUT(TMO)) dut_wrap (
    .clk(clk), .rst(rst), .pc_enable(pc_enable), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_req(imem_req_2), .imem_addr(imem_addr_2),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc_2), .pc_plus4(pc_plus4_2),
    .instr(instr_2), .opcode(opcode_2), .instr_valid(instr_valid_2),
    .misalign_err(misalign_err_2), .bus_err(bus_err_2)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles_2), .retired(retired_2)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic pe, input logic rv,
                       input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
    rst = r; pc_enable = pe; redirect_valid = rv; redirect_target = tgt;
    imem_ready = rdy; imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // directed vectors: inputs applied before an edge, outputs expected after it
  typedef struct {
    logic        r, pe, rv, rdy;
    logic [31:0] tgt, rd;
    logic [31:0] e_pc, e_instr;
    logic        e_iv, e_req, e_mis, e_bus;
    logic [31:0] e_stall, e_ret;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic r, logic pe, logic rv, logic [31:0] tgt, logic rdy,
                              logic [31:0] rd, logic [31:0] e_pc, logic [31:0] e_instr,
                              logic e_iv, logic e_req, logic e_mis, logic e_bus,
                              logic [31:0] e_stall, logic [31:0] e_ret);
    vec_t v;
    v.r = r; v.pe = pe; v.rv = rv; v.tgt = tgt; v.rdy = rdy; v.rd = rd;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_iv = e_iv; v.e_req = e_req;
    v.e_mis = e_mis; v.e_bus = e_bus; v.e_stall = e_stall; v.e_ret = e_ret;
    vt.push_back(v);
  endfunction

  // behavioural model for the random run
  localparam int PH_FETCH = 0, PH_EXEC = 1, PH_HALT = 2;
  int          m_ph, m_waited;
  logic [31:0] m_pc, m_ir, m_stall, m_ret;
  logic        m_mis, m_bus;

  task automatic model_step();
    if (rst) begin
      m_ph = PH_FETCH; m_waited = 0; m_pc = 32'h0; m_ir = NOP;
      m_mis = 1'b0; m_bus = 1'b0; m_stall = 0; m_ret = 0;
    end else if (m_ph == PH_FETCH) begin
      if (imem_ready) begin
        m_ir = imem_rdata;
        m_ph = PH_EXEC;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_bus = 1'b1;
          m_ph  = PH_HALT;
        end
      end
    end else if (m_ph == PH_EXEC) begin
      if (!pc_enable) begin
        m_stall = m_stall + 1;
      end else if (redirect_valid && (redirect_target % 4 != 0)) begin
        m_mis = 1'b1;
        m_ph  = PH_HALT;
      end else begin
        m_ret    = m_ret + 1;
        m_pc     = redirect_valid ? redirect_target : m_pc + 32'd4;
        m_waited = 0;
        m_ph     = PH_FETCH;
      end
    end
  endtask

  task automatic model_check();
    logic [31:0] e_instr;
    e_instr = (m_ph == PH_EXEC) ? m_ir : NOP;
    chk("rnd pc", pc, m_pc);
    chk("rnd pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("rnd instr", instr, e_instr);
    chk("rnd opcode", {25'd0, opcode}, {25'd0, e_instr[6:0]});
    chk("rnd instr_valid", {31'd0, instr_valid}, {31'd0, m_ph == PH_EXEC});
    chk("rnd imem_req", {31'd0, imem_req}, {31'd0, m_ph == PH_FETCH});
    if (m_ph == PH_FETCH) chk("rnd imem_addr", imem_addr, m_pc);
    chk("rnd misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    chk("rnd bus_err", {31'd0, bus_err}, {31'd0, m_bus});
`ifdef FETCH_PERF_CNT_EN
    chk("rnd stall_cycles", stall_cycles, m_stall);
    chk("rnd retired", retired, m_ret);
`endif
  endtask

  initial begin
    //  r pe rv tgt        rdy rdata  pc        instr iv req mis bus stall ret
    add(1, 0, 0, 32'h0,   0, 32'h0, 32'h0,   NOP,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 32'h0,   0, 32'h0, 32'h0,   NOP,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 32'h0,   1, NOP,   32'h0,   NOP,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h0,   0, 32'h0, 32'h4,   NOP,  0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 32'h0,   1, NOP,   32'h4,   NOP,  1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 32'h0,   0, 32'h0, 32'h8,   NOP,  0, 1, 0, 0, 0, 2);
    add(0, 0, 0, 32'h0,   1, LW,    32'h8,   LW,   1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 32'h0,   1, NOP,   32'h8,   LW,   1, 0, 0, 0, 1, 2);
    add(0, 1, 0, 32'h0,   0, 32'h0, 32'hC,   NOP,  0, 1, 0, 0, 1, 3);
    add(0, 0, 0, 32'h0,   1, ADDI,  32'hC,   ADDI, 1, 0, 0, 0, 1, 3);
    add(0, 1, 0, 32'h0,   0, 32'h0, 32'h10,  NOP,  0, 1, 0, 0, 1, 4);
    add(0, 0, 0, 32'h0,   1, NOP,   32'h10,  NOP,  1, 0, 0, 0, 1, 4);
    add(0, 0, 1, 32'h100, 0, 32'h0, 32'h10,  NOP,  1, 0, 0, 0, 2, 4);
    add(0, 1, 1, 32'h100, 0, 32'h0, 32'h100, NOP,  0, 1, 0, 0, 2, 5);
    add(0, 0, 0, 32'h0,   1, JAL,   32'h100, JAL,  1, 0, 0, 0, 2, 5);
    add(0, 1, 1, 32'h102, 0, 32'h0, 32'h100, NOP,  0, 0, 1, 0, 2, 5);
    add(0, 1, 0, 32'h0,   1, ADDI,  32'h100, NOP,  0, 0, 1, 0, 2, 5);
    add(1, 0, 0, 32'h0,   0, 32'h0, 32'h0,   NOP,  0, 1, 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].pe, vt[i].rv, vt[i].tgt, vt[i].rdy, vt[i].rd);
      tick();
      chk($sformatf("vec%0d pc", i), pc, vt[i].e_pc);
      chk($sformatf("vec%0d pc_plus4", i), pc_plus4, vt[i].e_pc + 32'd4);
      chk($sformatf("vec%0d instr", i), instr, vt[i].e_instr);
      chk($sformatf("vec%0d opcode", i), {25'd0, opcode}, {25'd0, vt[i].e_instr[6:0]});
      chk($sformatf("vec%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vt[i].e_iv});
      chk($sformatf("vec%0d imem_req", i), {31'd0, imem_req}, {31'd0, vt[i].e_req});
      if (vt[i].e_req) chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].e_pc);
      chk($sformatf("vec%0d misalign_err", i), {31'd0, misalign_err}, {31'd0, vt[i].e_mis});
      chk($sformatf("vec%0d bus_err", i), {31'd0, bus_err}, {31'd0, vt[i].e_bus});
      if (i <= 12) chk($sformatf("vec%0d wrap pc", i), pc_2, vt[i].e_pc - 32'd4);
`ifdef FETCH_PERF_CNT_EN
      chk($sformatf("vec%0d stall_cycles", i), stall_cycles, vt[i].e_stall);
      chk($sformatf("vec%0d retired", i), retired, vt[i].e_ret);
`endif
    end

    // timeout: last vector reset the DUT, so imem_req rose at that edge
    for (int i = 1; i <= TMO; i++) begin
      drive(0, 1, 1, 32'h100, 0, 32'h0);
      tick();
      chk($sformatf("tmo%0d bus_err", i), {31'd0, bus_err}, {31'd0, i == TMO});
      chk($sformatf("tmo%0d imem_req", i), {31'd0, imem_req}, {31'd0, i != TMO});
      chk($sformatf("tmo%0d pc", i), pc, 32'h0);
    end
    drive(0, 1, 0, 32'h0, 1, LW);
    tick();
    chk("tmo held bus_err", {31'd0, bus_err}, 32'd1);
    chk("tmo held instr_valid", {31'd0, instr_valid}, 32'd0);

    // reset mid-fetch with a late response arriving on the reset edge
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    tick();
    drive(0, 1, 0, 32'h0, 1, ADDI);
    tick();
    drive(0, 1, 0, 32'h0, 0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h0, 0, 32'h0);
      tick();
    end
    drive(1, 0, 0, 32'h0, 1, LW);
    tick();
    chk("rstmid pc", pc, 32'h0);
    chk("rstmid instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rstmid imem_req", {31'd0, imem_req}, 32'd1);
    chk("rstmid instr", instr, NOP);
    drive(0, 1, 0, 32'h0, 0, LW);
    tick();
    chk("rstmid discard", {31'd0, instr_valid}, 32'd0);
    drive(0, 0, 0, 32'h0, 1, ADDI);
    tick();
    chk("rstmid refetch instr", instr, ADDI);
    chk("wrap pc after rstmid", pc_2, 32'hFFFF_FFFC);

    // randomized run against the model
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    model_step();
    tick();
    model_check();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tgt;
      tgt = $urandom & 32'h0000_FFFC;
      if ($urandom_range(7) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
      drive((m_ph == PH_HALT) ? ($urandom_range(7) == 0) : ($urandom_range(199) == 0),
            $urandom_range(3) != 0, $urandom_range(3) == 0, tgt,
            (c % 400 < 40) ? 1'b0 : ($urandom_range(2) == 0), $urandom);
      model_step();
      tick();
      model_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
